// File: rtl/mod12_disp_pkg.sv
// Shared types and constants for the mod-12 counter display path.
package mod12_disp_pkg;

  typedef enum logic {UNITS, TENS} digit_sel_e;

  localparam int unsigned MAX_COUNT = 11;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'h06;

  // Active-low {g,f,e,d,c,b,a} patterns for digits 0..9.
  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

endpackage

// File: rtl/mod12_seg_decoder.sv
// Combinational BCD digit to active-low 7-segment code; non-decimal codes blank.
module mod12_seg_decoder
  import mod12_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_BLANK;
    if (digit < 4'd10) seg_n = SEG_DIGIT[digit];
  end

endmodule

// File: rtl/mod12_seg_display.sv
// Samples a mod-12 count and multiplexes it onto a 2-digit common-anode display.
// Build option: MOD12_ZERO_BLANK_EN enables leading-zero blanking of the tens digit.
module mod12_seg_display
  import mod12_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 1000,
  parameter int unsigned BLINK_CYCLES = 4000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] data_in,
  input  logic       sample,
  output logic [6:0] seg_n,
  output logic [1:0] an_n,
  output logic       wrap_pulse,
  output logic       err
);

  localparam logic [15:0] REFRESH_LAST = 16'(REFRESH_DIV - 1);
  localparam logic [15:0] BLINK_LOAD   = 16'(BLINK_CYCLES);
  localparam logic [3:0]  TOP_CODE     = 4'(MAX_COUNT);

  logic [3:0]  shadow;
  logic [15:0] refresh_cnt, refresh_next;
  logic [15:0] blink_cnt;
  digit_sel_e  state, state_next;

  logic       in_range, is_wrap;
  logic       tens;
  logic [3:0] units, digit_sel;
  logic [6:0] seg_code, seg_next;
  logic [1:0] an_next;

  assign in_range = (data_in <= TOP_CODE);
  assign is_wrap  = sample && in_range &&
                    (((shadow == TOP_CODE) && (data_in == 4'd0)) ||
                     ((shadow == 4'd0) && (data_in == TOP_CODE)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow     <= '0;
      err        <= 1'b0;
      wrap_pulse <= 1'b0;
      blink_cnt  <= '0;
    end else begin
      wrap_pulse <= is_wrap;
      if (sample) begin
        if (in_range) shadow <= data_in;
        err <= !in_range;
      end
      // A wrap reloads rather than adds, so back-to-back wraps extend blanking.
      if (is_wrap)                blink_cnt <= BLINK_LOAD;
      else if (blink_cnt != '0)   blink_cnt <= blink_cnt - 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      refresh_cnt <= '0;
      state       <= UNITS;
    end else begin
      refresh_cnt <= refresh_next;
      state       <= state_next;
    end
  end

  always_comb begin
    refresh_next = refresh_cnt + 16'd1;
    state_next   = state;
    if (refresh_cnt == REFRESH_LAST) begin
      refresh_next = '0;
      state_next   = (state == UNITS) ? TENS : UNITS;
    end
  end

  assign tens      = (shadow >= 4'd10);
  assign units     = tens ? (shadow - 4'd10) : shadow;
  assign digit_sel = (state == TENS) ? {3'b000, tens} : units;

  mod12_seg_decoder u_decoder (
    .digit (digit_sel),
    .seg_n (seg_code)
  );

  // Anode and segment come from the same state value, so they always register together.
  always_comb begin
    an_next  = 2'b11;
    seg_next = SEG_BLANK;
    if (blink_cnt != '0) begin
      an_next  = 2'b11;
      seg_next = SEG_BLANK;
    end else if (err) begin
      an_next  = (state == UNITS) ? 2'b10 : 2'b01;
      seg_next = SEG_E;
    end else begin
`ifdef MOD12_ZERO_BLANK_EN
      if (!((state == TENS) && !tens)) begin
        an_next  = (state == UNITS) ? 2'b10 : 2'b01;
        seg_next = seg_code;
      end
`else
      an_next  = (state == UNITS) ? 2'b10 : 2'b01;
      seg_next = seg_code;
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seg_n <= SEG_BLANK;
      an_n  <= 2'b11;
    end else begin
      seg_n <= seg_next;
      an_n  <= an_next;
    end
  end

endmodule
